clk_en_gen: RTL and testbench
=============================

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent enable channels, range 1..16.
REQ-002 SHALL have parameter WIDTH, default 16: divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset; 0 disables the channel.
REQ-004 SHALL have port clk, input, 1: single clock for the block; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid, input, 1: divisor write request.
REQ-007 SHALL have port cfg_ready, output, 1: write accepted when cfg_valid && cfg_ready at a rising edge.
REQ-008 SHALL have port cfg_chan, input, max(1,$clog2(CHANNELS)): target channel of the write.
REQ-009 SHALL have port cfg_div, input, WIDTH: new divisor; 0 means channel disabled.
REQ-010 SHALL have port sync, input, 1: realign all channels.
REQ-011 SHALL have port ce, output, CHANNELS: per-channel clock-enable pulses.
REQ-012 SHALL have port clk_out, output, CHANNELS: per-channel divided square wave (see Configuration).

Function
REQ-013 Per channel i, SHALL hold registers cnt[i] (WIDTH), div[i] (WIDTH), shadow[i] (WIDTH), pending[i] (1), tog[i] (1).
REQ-014 ce[i] SHALL equal (div[i] != 0) && (cnt[i] == div[i]-1), decoded from registers only, with no input-to-output path.
REQ-015 When div[i] != 0: if ce[i], cnt[i] SHALL wrap to 0; otherwise cnt[i] SHALL increment by 1.
REQ-016 When div[i] == 0, cnt[i] SHALL hold at 0 and ce[i] SHALL be 0.
REQ-017 div[i] == 1 SHALL give ce[i] high every cycle; div[i] == D SHALL give exactly one ce pulse per D cycles.
REQ-018 cfg_ready SHALL equal !pending[cfg_chan] when cfg_chan < CHANNELS, and 1 otherwise.
REQ-019 An accepted write with cfg_chan >= CHANNELS SHALL be discarded with no state change.
REQ-020 An accepted write to channel i SHALL set shadow[i] = cfg_div and pending[i] = 1.
REQ-021 When pending[i] and (ce[i] or div[i] == 0) at an edge, the block SHALL load div[i] = shadow[i], set cnt[i] = 0, and clear pending[i] (glitch-free update at period boundary).
REQ-022 A write accepted in the same cycle as a wrap of that channel SHALL NOT take effect at that wrap; it SHALL apply at the next qualifying edge.
REQ-023 Writing the currently active divisor SHALL still follow REQ-021, with no disturbance to pulse spacing.
REQ-024 sync high at an edge SHALL set every cnt[i] = 0 and tog[i] = 0, and SHALL apply every pending shadow immediately; sync SHALL take priority over wrap.
REQ-025 A write accepted in the same cycle as sync SHALL remain pending after that edge.
REQ-026 Channels SHALL be fully independent except for sync.

Reset
REQ-027 While rst is high at an edge, the block SHALL set cnt = 0, div = DEFAULT_DIV, shadow = 0, pending = 0, and tog = 0 for all channels.
REQ-028 rst SHALL dominate sync and cfg writes; a write presented during reset SHALL be lost.
REQ-029 In the first cycle after reset, ce SHALL equal all-ones if DEFAULT_DIV == 1 and all-zeros otherwise; cfg_ready SHALL be 1 and clk_out SHALL be 0.
REQ-030 Reset mid-period SHALL discard partial counts and any pending update, with no extra ce pulse.

Configuration
REQ-031 Macro CLK_EN_GEN_TOGGLE_EN SHALL control the square-wave output.
REQ-032 With CLK_EN_GEN_TOGGLE_EN defined, tog[i] SHALL invert on every edge where ce[i] is high and not overridden by sync or rst, and clk_out[i] SHALL equal tog[i] (period 2*div[i], 50% duty).
REQ-033 Without CLK_EN_GEN_TOGGLE_EN, the tog registers SHALL be omitted and clk_out SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-034 Bench SHALL cover: reset with DEFAULT_DIV=3 -> ce[0] high in cycles 3, 6, 9 after release; clk_out[0] toggles at each of those.
REQ-035 Bench SHALL cover: write div=5 to ch1 at cnt=0 of a div-2 period -> the current 2-cycle period completes, then pulses every 5 cycles; cfg_ready low only until the update applies.
REQ-036 Bench SHALL cover: write div=0 to ch0, then later div=4 -> ce[0] stops after the next wrap; the div=4 write applies one edge after acceptance and the first pulse follows 4 cycles later.
REQ-037 Bench SHALL cover: ch0 div=3, ch1 div=7 free-running, sync pulsed -> both cnt=0; next ce at +3 and +7 cycles respectively; clk_out both 0.
REQ-038 Bench SHALL cover: write accepted on the same edge as the ch0 wrap -> old divisor is used for one more period; cfg_ready low throughout.
REQ-039 Bench SHALL cover: CHANNELS=3, write to cfg_chan=3 -> accepted with cfg_ready=1 and no channel changes; repeat the run without the macro -> clk_out stays 0.

Source files
------------

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator; divisor updates land on period boundaries.
// Optional square-wave outputs are built when CLK_EN_GEN_TOGGLE_EN is defined.
module clk_en_gen #(
   parameter int  CHANNELS    = 2,
   parameter int  WIDTH       = 16,
   parameter int  DEFAULT_DIV = 2,
   localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [WIDTH-1:0]    cfg_div,
   input  logic                sync,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] clk_out
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0]    cnt_q    [CHANNELS];
   logic [WIDTH-1:0]    cnt_d    [CHANNELS];
   logic [WIDTH-1:0]    div_q    [CHANNELS];
   logic [WIDTH-1:0]    div_d    [CHANNELS];
   logic [WIDTH-1:0]    shadow_q [CHANNELS];
   logic [WIDTH-1:0]    shadow_d [CHANNELS];
   logic [CHANNELS-1:0] pending_q;
   logic [CHANNELS-1:0] pending_d;
   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] load;

   // Pulse decode uses registers only, so ce has no path from any input
   always_comb begin
      ce = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ce[i] = (div_q[i] != '0) && (cnt_q[i] == (div_q[i] - ONE));
      end
   end

   // Out-of-range channels are always ready and their writes match no channel
   always_comb begin
      cfg_ready = 1'b1;
      wr_hit    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cfg_ready = (cfg_chan == CW'(i)) ? ~pending_q[i] : cfg_ready;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
      end
   end

   // Per-channel next state; a write sets pending only after this edge's reload decision
   always_comb begin
      pending_d = pending_q;
      load      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]    = cnt_q[i];
         div_d[i]    = div_q[i];
         shadow_d[i] = shadow_q[i];
         load[i]     = pending_q[i] && (ce[i] || (div_q[i] == '0));
         if (sync) begin
            cnt_d[i] = '0;
            if (pending_q[i]) begin
               div_d[i]     = shadow_q[i];
               pending_d[i] = 1'b0;
            end else begin
               div_d[i]     = div_q[i];
            end
         end else if (load[i]) begin
            div_d[i]     = shadow_q[i];
            cnt_d[i]     = '0;
            pending_d[i] = 1'b0;
         end else if (ce[i] || (div_q[i] == '0)) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + ONE;
         end
         if (wr_hit[i]) begin
            shadow_d[i]  = cfg_div;
            pending_d[i] = 1'b1;
         end else begin
            shadow_d[i]  = shadow_q[i];
         end
      end
   end

   // Channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= '0;
            div_q[i]    <= DIV_RST;
            shadow_q[i] <= '0;
         end
         pending_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

`ifdef CLK_EN_GEN_TOGGLE_EN
   logic [CHANNELS-1:0] tog_q;
   logic [CHANNELS-1:0] tog_d;

   // Square wave flips on each pulse; sync realigns it low
   always_comb begin
      if (sync) begin
         tog_d = '0;
      end else begin
         tog_d = tog_q ^ ce;
      end
   end

   // Toggle state register
   always_ff @(posedge clk) begin
      if (rst) begin
         tog_q <= '0;
      end else begin
         tog_q <= tog_d;
      end
   end

   assign clk_out = tog_q;
`else
   assign clk_out = '0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: vector table, directed corner sequences and a
// random run against a time-based reference model (modulo arithmetic on absolute cycle).
module tb_clk_en_gen;
   localparam int NCH = 3;
   localparam int WID = 8;
   localparam int DEF = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_chan = 2'd0;
   logic [7:0] cfg_div = 8'd0;
   logic       sync = 1'b0;
   logic [2:0] ce;
   logic [2:0] clk_out;

   int total = 0;
   int bad   = 0;

   // reference model: each channel's period start is an absolute cycle number
   int t = 0;
   int m_div    [NCH];
   int m_start  [NCH];
   int m_shadow [NCH];
   int m_pulses [NCH];
   bit m_pend   [NCH];
   bit m_valid = 1'b0;

   logic [2:0] obs_ce;
   logic [2:0] obs_clk;
   logic       obs_rdy;

   typedef struct {
      bit         v;
      int         ch;
      int         dv;
      bit         r;
      bit         chk;
      logic [2:0] e_ce;
      bit         e_rdy;
      logic [2:0] e_clk;
   } vec_t;

   vec_t tbl [12];

   clk_en_gen #(.CHANNELS(NCH), .WIDTH(WID), .DEFAULT_DIV(DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_chan (cfg_chan),
      .cfg_div  (cfg_div),
      .sync     (sync),
      .ce       (ce),
      .clk_out  (clk_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic bit m_ce(int i);
      if (m_div[i] == 0) return 1'b0;
      return ((t - m_start[i]) % m_div[i]) == (m_div[i] - 1);
   endfunction

   function automatic bit m_ready(int ch);
      if (ch >= NCH) return 1'b1;
      return !m_pend[ch];
   endfunction

   function automatic logic [2:0] m_clk();
      logic [2:0] r = 3'b000;
`ifdef CLK_EN_GEN_TOGGLE_EN
      for (int i = 0; i < NCH; i++) r[i] = ((m_pulses[i] % 2) == 1);
`endif
      return r;
   endfunction

   task automatic m_update(bit v, int ch, int dv, bit sy, bit r);
      bit acc;
      bit cev [NCH];
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            m_div[i] = DEF; m_start[i] = t + 1; m_shadow[i] = 0;
            m_pend[i] = 1'b0; m_pulses[i] = 0;
         end
         m_valid = 1'b1;
      end else begin
         acc = v && m_ready(ch);
         for (int i = 0; i < NCH; i++) cev[i] = m_ce(i);
         for (int i = 0; i < NCH; i++) begin
            if (sy) begin
               m_start[i] = t + 1;
               m_pulses[i] = 0;
               if (m_pend[i]) begin
                  m_div[i] = m_shadow[i];
                  m_pend[i] = 1'b0;
               end
            end else begin
               if (cev[i]) m_pulses[i]++;
               if (m_pend[i] && (cev[i] || m_div[i] == 0)) begin
                  m_div[i] = m_shadow[i];
                  m_start[i] = t + 1;
                  m_pend[i] = 1'b0;
               end
            end
            if (acc && ch == i) begin
               m_shadow[i] = dv;
               m_pend[i] = 1'b1;
            end
         end
      end
      t++;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, t);
      end
   endtask

   // one clock cycle: drive, sample at negedge and compare with model, then advance model
   task automatic tick(bit v, int ch, int dv, bit sy, bit r);
      logic [2:0] exp_ce;
      cfg_valid = v;
      cfg_chan  = 2'(ch);
      cfg_div   = 8'(dv);
      sync      = sy;
      rst       = r;
      @(negedge clk);
      obs_ce  = ce;
      obs_rdy = cfg_ready;
      obs_clk = clk_out;
      if (m_valid) begin
         for (int i = 0; i < NCH; i++) exp_ce[i] = m_ce(i);
         check("model_ce", 32'(obs_ce), 32'(exp_ce));
         check("model_ready", 32'(obs_rdy), 32'(m_ready(ch)));
         check("model_clk_out", 32'(obs_clk), 32'(m_clk()));
      end
      @(posedge clk);
      m_update(v, ch, dv, sy, r);
      #1;
   endtask

   task automatic idle(int ch);
      tick(1'b0, ch, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      tick(1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic wait_ce(int ch, int budget, output int n, output bit saw_rdy);
      bit hit = 1'b0;
      n = 0;
      saw_rdy = 1'b0;
      while (!hit && n < budget) begin
         n++;
         idle(ch);
         if (obs_rdy) saw_rdy = 1'b1;
         if (obs_ce[ch]) hit = 1'b1;
      end
      if (!hit) n = -1;
   endtask

   function automatic vec_t mk(bit v, int ch, int dv, bit r, bit chk,
                               logic [2:0] ec, bit er, logic [2:0] eclk);
      vec_t x;
      x.v = v; x.ch = ch; x.dv = dv; x.r = r; x.chk = chk;
      x.e_ce = ec; x.e_rdy = er; x.e_clk = eclk;
      return x;
   endfunction

   initial begin
      int n;
      int cnt0;
      int first0;
      int first1;
      bit saw;
      logic [2:0] eclk;

      // reset (write during reset must be lost), then DEFAULT_DIV=3 pulse train with
      // writes to the nonexistent channel 3 that must not disturb anything
      tbl[0]  = mk(1'b0, 0, 0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
      tbl[1]  = mk(1'b1, 0, 9, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
      tbl[2]  = mk(1'b1, 3, 5, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000);
      tbl[3]  = mk(1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000);
      tbl[4]  = mk(1'b1, 3, 1, 1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
      tbl[5]  = mk(1'b0, 1, 0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b111);
      tbl[6]  = mk(1'b1, 3, 0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b111);
      tbl[7]  = mk(1'b0, 2, 0, 1'b0, 1'b1, 3'b111, 1'b1, 3'b111);
      tbl[8]  = mk(1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000);
      tbl[9]  = mk(1'b1, 3, 7, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000);
      tbl[10] = mk(1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
      tbl[11] = mk(1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b111);

      for (int k = 0; k < 12; k++) begin
         tick(tbl[k].v, tbl[k].ch, tbl[k].dv, 1'b0, tbl[k].r);
         if (tbl[k].chk) begin
`ifdef CLK_EN_GEN_TOGGLE_EN
            eclk = tbl[k].e_clk;
`else
            eclk = 3'b000;
`endif
            check("tbl_ce", 32'(obs_ce), 32'(tbl[k].e_ce));
            check("tbl_ready", 32'(obs_rdy), 32'(tbl[k].e_rdy));
            check("tbl_clk_out", 32'(obs_clk), 32'(eclk));
         end
      end

      // ch1 to div 2, then div 5 written at cnt=0: current period completes, then every 5
      do_reset();
      tick(1'b1, 1, 2, 1'b0, 1'b0);
      idle(1);
      idle(1);
      tick(1'b1, 1, 5, 1'b0, 1'b0);
      check("d35_ready_at_write", 32'(obs_rdy), 32'd1);
      idle(1);
      check("d35_old_period_ce", 32'(obs_ce[1]), 32'd1);
      check("d35_ready_pending", 32'(obs_rdy), 32'd0);
      wait_ce(1, 20, n, saw);
      check("d35_first_gap", 32'(n), 32'd5);
      check("d35_ready_after_apply", 32'(saw), 32'd1);
      wait_ce(1, 20, n, saw);
      check("d35_second_gap", 32'(n), 32'd5);

      // write landing on the ch0 wrap edge: old divisor runs one more period
      do_reset();
      idle(0);
      idle(0);
      tick(1'b1, 0, 2, 1'b0, 1'b0);
      check("d38_wrap_ce", 32'(obs_ce[0]), 32'd1);
      check("d38_ready_at_write", 32'(obs_rdy), 32'd1);
      wait_ce(0, 20, n, saw);
      check("d38_old_period", 32'(n), 32'd3);
      check("d38_ready_low", 32'(saw), 32'd0);
      wait_ce(0, 20, n, saw);
      check("d38_new_period", 32'(n), 32'd2);

      // disable ch0, then re-enable with div 4
      do_reset();
      tick(1'b1, 0, 0, 1'b0, 1'b0);
      idle(0);
      idle(0);
      check("d36_last_wrap", 32'(obs_ce[0]), 32'd1);
      cnt0 = 0;
      for (int k = 0; k < 4; k++) begin
         idle(0);
         if (obs_ce[0]) cnt0++;
      end
      check("d36_disabled_quiet", 32'(cnt0), 32'd0);
      tick(1'b1, 0, 4, 1'b0, 1'b0);
      check("d36_ready_when_idle", 32'(obs_rdy), 32'd1);
      idle(0);
      check("d36_apply_edge_ce", 32'(obs_ce[0]), 32'd0);
      wait_ce(0, 20, n, saw);
      check("d36_first_pulse", 32'(n), 32'd4);

      // free-running ch0 div 3 and ch1 div 7, then sync
      do_reset();
      tick(1'b1, 1, 7, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) idle(0);
      tick(1'b0, 0, 0, 1'b1, 1'b0);
      first0 = 0;
      first1 = 0;
      for (int k = 1; k <= 7; k++) begin
         idle(0);
         if (k == 1) begin
            check("d37_clk_out_low", 32'(obs_clk[1:0]), 32'd0);
            check("d37_ce_low", 32'(obs_ce[1:0]), 32'd0);
         end
         if (obs_ce[0] && first0 == 0) first0 = k;
         if (obs_ce[1] && first1 == 0) first1 = k;
      end
      check("d37_ch0_first", 32'(first0), 32'd3);
      check("d37_ch1_first", 32'(first1), 32'd7);

      // random traffic against the model
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         tick(1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
              ($urandom_range(15, 0) == 0), ($urandom_range(63, 0) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
